// File: rtl/multdiv_iter_mult_if.sv
// Start/operand/result bundle between the multdiv issue logic and the
// iterative multiplier.
interface multdiv_iter_mult_if #(
   parameter int WIDTH = 32
);
   logic                    ctrl_MULT;
   logic signed [WIDTH-1:0] data_operandA;
   logic signed [WIDTH-1:0] data_operandB;
   logic        [WIDTH-1:0] data_result;
   logic                    data_exception;
   logic                    data_resultRDY;

   modport master (
      output ctrl_MULT,
      output data_operandA,
      output data_operandB,
      input  data_result,
      input  data_exception,
      input  data_resultRDY
   );

   modport slave (
      input  ctrl_MULT,
      input  data_operandA,
      input  data_operandB,
      output data_result,
      output data_exception,
      output data_resultRDY
   );
endinterface

// File: rtl/multdiv_iter_mult.sv
// Iterative signed shift-and-add multiplier: one partial product per clock,
// sign applied at the end, low WIDTH bits plus overflow flag and a RDY pulse.
module multdiv_iter_mult #(
   parameter int WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   multdiv_iter_mult_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t state, state_nxt;

   logic                 load, step, finish;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     count;
   logic                 sign;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     result_q;
   logic                 exception_q;
   logic                 rdy_q;

   // Magnitude of a two's complement value; the most negative value maps
   // to its unsigned 2^(WIDTH-1) bit pattern, which is exactly right here.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                     input logic               neg);
      return neg ? (~mag + (2*WIDTH)'(1)) : mag;
   endfunction

   // Product fits in signed WIDTH bits only if the top WIDTH+1 bits agree.
   function automatic logic overflow(input logic [2*WIDTH-1:0] p);
      logic [WIDTH:0] hi;
      hi = p[2*WIDTH-1:WIDTH-1];
      return !((hi == '0) || (hi == '1));
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A start request overrides whatever is in flight.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      if (bus.ctrl_MULT) begin
         load      = 1'b1;
         state_nxt = RUN;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            RUN: begin
               step = 1'b1;
               if (count == LAST_ITER) begin
                  state_nxt = FIN;
               end
            end
            FIN: begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign product = apply_sign(acc, sign);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         count       <= '0;
         sign        <= 1'b0;
         result_q    <= '0;
         exception_q <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (load) begin
            mcand  <= {{WIDTH{1'b0}}, abs_val(bus.data_operandA)};
            mplier <= abs_val(bus.data_operandB);
            sign   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            acc    <= '0;
            count  <= '0;
         end else if (step) begin
            acc    <= acc + (mcand & {(2*WIDTH){mplier[0]}});
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
         end else if (finish) begin
            result_q    <= product[WIDTH-1:0];
            exception_q <= overflow(product);
            rdy_q       <= 1'b1;
         end
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exception_q;
   assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter_mult.sv
// Directed-vector and corner-sequence bench for the iterative multiplier.
module tb_multdiv_iter_mult;

   localparam int WIDTH   = 32;
   localparam int LATENCY = 33;
   localparam int TIMEOUT = 45;

   logic clock;
   logic reset_n;
   int   tests;
   int   fails;

   multdiv_iter_mult_if #(.WIDTH(WIDTH)) bus ();

   multdiv_iter_mult #(.WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called just after a clock edge; presents operands for exactly one edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
   endtask

   // Edges counted after the start edge until RDY is seen; -1 on timeout.
   task automatic wait_rdy(output int k);
      k = -1;
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc);
      longint p;
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
   endtask

   int          k;
   logic [31:0] ra, rb, er;
   logic        ee;
   int          seen;

   initial begin
      tests = 0;
      fails = 0;

      vecs[0]  = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0};
      vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0};
      vecs[2]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_002A, 1'b0};
      vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
      vecs[6]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
      vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[9]  = '{32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 1'b1};
      vecs[10] = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};
      vecs[11] = '{32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0};

      reset_n           = 1'b0;
      bus.ctrl_MULT     = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("reset_result", 64'(bus.data_result), 64'h0);
      check("reset_exc",    64'(bus.data_exception), 64'h0);
      check("reset_rdy",    64'(bus.data_resultRDY), 64'h0);

      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_rdy(k);
         check($sformatf("v%0d_latency", i), 64'(k), 64'(LATENCY));
         check($sformatf("v%0d_result", i), 64'(bus.data_result), 64'(vecs[i].res));
         check($sformatf("v%0d_exc", i), 64'(bus.data_exception), 64'(vecs[i].exc));
         @(posedge clock);
         #1;
         check($sformatf("v%0d_rdy_drop", i), 64'(bus.data_resultRDY), 64'h0);
      end

      // Restart at edge 10 of a running operation.
      start_op(32'd3, 32'd5);
      repeat (9) @(posedge clock);
      #1;
      start_op(32'd100, 32'hFFFF_FFFE);
      wait_rdy(k);
      check("restart_latency", 64'(k), 64'(LATENCY));
      check("restart_result", 64'(bus.data_result), 64'hFFFF_FF38);
      check("restart_exc", 64'(bus.data_exception), 64'h0);
      @(posedge clock);
      #1;

      // Asynchronous reset in the middle of an operation.
      start_op(32'd12, 32'd12);
      repeat (19) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_result", 64'(bus.data_result), 64'h0);
      check("midrst_exc", 64'(bus.data_exception), 64'h0);
      check("midrst_rdy", 64'(bus.data_resultRDY), 64'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) seen++;
      end
      check("midrst_no_rdy", 64'(seen), 64'h0);
      start_op(32'd12, 32'd12);
      wait_rdy(k);
      check("postrst_latency", 64'(k), 64'(LATENCY));
      check("postrst_result", 64'(bus.data_result), 64'h0000_0090);
      check("postrst_exc", 64'(bus.data_exception), 64'h0);

      // Back-to-back random operations, each new start issued in the RDY cycle.
      ra = $urandom;
      rb = $urandom_range(0, 255);
      start_op(ra, rb);
      for (int i = 0; i < 10; i++) begin
         model(ra, rb, er, ee);
         wait_rdy(k);
         check($sformatf("rnd%0d_latency", i), 64'(k), 64'(LATENCY));
         check($sformatf("rnd%0d_result", i), 64'(bus.data_result), 64'(er));
         check($sformatf("rnd%0d_exc", i), 64'(bus.data_exception), 64'(ee));
         if (k < 0) break;
         ra = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 4000)) - 2000);
         rb = (i % 3 == 0) ? $urandom : 32'($signed($urandom_range(0, 4000)) - 2000);
         start_op(ra, rb);
         check($sformatf("rnd%0d_rdy_drop", i), 64'(bus.data_resultRDY), 64'h0);
      end
      wait_rdy(k);
      model(ra, rb, er, ee);
      check("rnd_last_result", 64'(bus.data_result), 64'(er));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
